// File: rtl/op_sequencer.sv
// op_sequencer: sequences one 24-game arithmetic step (select, operate, write back, compact)
// Ports: clk; rst (async, active-low); load + init1..4 start a new game; key_vld + key deliver
//    keypad codes; num1..4 live numbers (dead slots read 0); how_many = live count - 1;
//    busy during EXEC/DIV/WRITE; err pulses in a rejecting WRITE; win when one 24 remains.
// Build option: define UNDO_EN to add a one-deep snapshot restored by key E.
module op_sequencer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] init1,
   input  logic [W-1:0] init2,
   input  logic [W-1:0] init3,
   input  logic [W-1:0] init4,
   input  logic         key_vld,
   input  logic [3:0]   key,
   output logic [W-1:0] num1,
   output logic [W-1:0] num2,
   output logic [W-1:0] num3,
   output logic [W-1:0] num4,
   output logic [1:0]   how_many,
   output logic         busy,
   output logic         err,
   output logic         win
);
   localparam logic [2:0] SEL1 = 3'd0, SEL2 = 3'd1, SELOP = 3'd2, EXEC = 3'd3;
   localparam logic [2:0] DIV = 3'd4, WRITE = 3'd5, DONE = 3'd6;
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] DLAST = CW'(W - 1);
   logic [2:0]   st;
   logic [W-1:0] num [4];
   logic [W-1:0] t [5];
   logic [W-1:0] nx [4];
   logic [1:0]   hm, in1, in2, op, km;
   logic [W-1:0] res, q, b, r, a_s, b_s, rd, rnx, qnx;
   logic [W:0]   rn, sum;
   logic [2*W-1:0] prod;
   logic         rej, dz, ge, slot_ok;
   logic [CW-1:0] dc;
`ifdef UNDO_EN
   logic [W-1:0] snap [4];
   logic [1:0]   snap_hm;
   logic         snap_v, undo;
   assign undo = key_vld && key == 4'hE && snap_v &&
                 (st == SEL1 || st == SEL2 || st == SELOP || st == DONE);
`endif
   // keys 1..4 map to slot 0..3; valid only inside the live count
   assign km      = key[1:0] - 2'd1;
   assign slot_ok = key_vld && key >= 4'd1 && key <= 4'd4 && km <= hm;
   assign a_s  = num[in1];
   assign b_s  = num[in2];
   assign sum  = {1'b0, a_s} + {1'b0, b_s};
   assign prod = {{W{1'b0}}, a_s} * {{W{1'b0}}, b_s};
   // restoring divide step: q shifts the dividend out MSB-first and the quotient in
   assign rn  = {r, q[W-1]};
   assign ge  = rn >= {1'b0, b};
   assign rd  = rn[W-1:0] - b;
   assign rnx = ge ? rd : rn[W-1:0];
   assign qnx = {q[W-2:0], ge};
   // commit view: result lands in in1, then everything above in2 drops one slot
   assign t[4] = '0;
   for (genvar g = 0; g < 4; g++) begin : g_cmp
      assign t[g]  = (in1 == 2'(g)) ? res : num[g];
      assign nx[g] = (2'(g) < in2) ? t[g] : (2'(g) < hm) ? t[g+1] : '0;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st <= DONE;
         for (int i = 0; i < 4; i++) num[i] <= '0;
         hm  <= '0;
         in1 <= '0;
         in2 <= '0;
         op  <= '0;
         res <= '0;
         q   <= '0;
         b   <= '0;
         r   <= '0;
         rej <= 1'b0;
         dz  <= 1'b0;
         dc  <= '0;
`ifdef UNDO_EN
         for (int i = 0; i < 4; i++) snap[i] <= '0;
         snap_hm <= '0;
         snap_v  <= 1'b0;
`endif
      end else if (load) begin
         num <= '{init1, init2, init3, init4};
         hm  <= 2'd3;
         in1 <= '0;
         in2 <= '0;
         st  <= SEL1;
`ifdef UNDO_EN
         snap_v <= 1'b0;
`endif
`ifdef UNDO_EN
      end else if (undo) begin
         num    <= snap;
         hm     <= snap_hm;
         snap_v <= 1'b0;
         st     <= SEL1;
`endif
      end else begin
         case (st)
            SEL1: if (slot_ok) begin
               in1 <= km;
               st  <= SEL2;
            end
            SEL2: if (slot_ok && km != in1) begin
               in2 <= km;
               st  <= SELOP;
            end else if (key_vld && key == 4'hF) st <= SEL1;
            SELOP: if (key_vld) begin
               if (key == 4'hA || key == 4'hB || key == 4'hD) begin
                  op <= key[1:0];
                  st <= EXEC;
               end else if (key == 4'hC) begin
                  q  <= a_s;
                  b  <= b_s;
                  r  <= '0;
                  dz <= b_s == '0;
                  dc <= '0;
                  st <= DIV;
               end else if (key == 4'hF) st <= SEL1;
            end
            EXEC: begin
               res <= (op == 2'b10) ? sum[W-1:0] : (op == 2'b11) ? a_s - b_s : prod[W-1:0];
               rej <= (op == 2'b10) ? sum[W] : (op == 2'b11) ? a_s < b_s : |prod[2*W-1:W];
               st  <= WRITE;
            end
            DIV: begin
               q  <= qnx;
               r  <= rnx;
               dc <= dc + 1'b1;
               if (dc == DLAST) begin
                  res <= qnx;
                  rej <= dz || rnx != '0;
                  st  <= WRITE;
               end
            end
            WRITE: begin
               if (!rej) begin
                  num <= nx;
                  hm  <= hm - 2'd1;
`ifdef UNDO_EN
                  snap    <= num;
                  snap_hm <= hm;
                  snap_v  <= 1'b1;
`endif
               end
               st <= (!rej && hm == 2'd1) ? DONE : SEL1;
            end
            default: st <= DONE;
         endcase
      end
   end
   assign num1     = num[0];
   assign num2     = num[1];
   assign num3     = num[2];
   assign num4     = num[3];
   assign how_many = hm;
   assign busy     = st == EXEC || st == DIV || st == WRITE;
   assign err      = st == WRITE && rej;
   assign win      = hm == 2'd0 && num[0] == W'(24);
endmodule
